// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and sizes for the register-file writeback controller.
package regfile_wb_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_CNT = 32;
  localparam int unsigned REG_AW  = 5;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_port_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, writeback-request and register-file port bundle for regfile_wb_ctrl.
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic                issue_valid;
  logic                issue_long;
  logic [REG_AW-1:0]   issue_rd;
  logic [REG_AW-1:0]   issue_rs1;
  logic [REG_AW-1:0]   issue_rs2;
  logic                issue_stall;

  logic                a_valid;
  logic [REG_AW-1:0]   a_rd;
  logic [XLEN-1:0]     a_data;
  logic                a_ready;

  logic                b_valid;
  logic [REG_AW-1:0]   b_rd;
  logic [XLEN-1:0]     b_data;
  logic                b_ready;

  logic                reg_wr;
  logic [REG_AW-1:0]   rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic [REG_CNT-1:0]  busy;

  modport master (
    output issue_valid, issue_long, issue_rd, issue_rs1, issue_rs2,
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  issue_stall, a_ready, b_ready, reg_wr, rd_addr, rd_data, busy
  );

  modport slave (
    input  issue_valid, issue_long, issue_rd, issue_rs1, issue_rs2,
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output issue_stall, a_ready, b_ready, reg_wr, rd_addr, rd_data, busy
  );

endinterface

// File: rtl/regfile_wb_ctrl_wb_arbiter.sv
// Write-port arbiter: pipeline (A) first, long unit (B) promoted after MaxWait refusals.
module regfile_wb_ctrl_wb_arbiter #(
  parameter int unsigned MaxWait = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_ready_o,
  output logic b_ready_o
);

  localparam logic [3:0] WaitMax = 4'(MaxWait);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       b_prio;

  always_comb begin
    b_prio    = b_valid_i && (wait_cnt_q == WaitMax);
    a_ready_o = a_valid_i && !b_prio;
    b_ready_o = b_valid_i && (!a_valid_i || b_prio);

    wait_cnt_d = wait_cnt_q;
    if (!b_valid_i || b_ready_o) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: arbitrates A/B writebacks, tracks registers owed by B,
// and stalls issue on RAW/WAW hazards against them.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned MaxWait = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  regfile_wb_ctrl_if.slave   bus_io
);

  logic [REG_CNT-1:0] busy_q, busy_d, set_mask, clr_mask;
  wr_port_t           wr_q, wr_d;
  logic               a_ready, b_ready, accept;

  regfile_wb_ctrl_wb_arbiter #(
    .MaxWait (MaxWait)
  ) u_arbiter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_valid_i (bus_io.a_valid),
    .b_valid_i (bus_io.b_valid),
    .a_ready_o (a_ready),
    .b_ready_o (b_ready)
  );

  always_comb begin
    bus_io.issue_stall = bus_io.issue_valid &&
                         (busy_q[bus_io.issue_rs1] || busy_q[bus_io.issue_rs2] ||
                          busy_q[bus_io.issue_rd]);
    accept = bus_io.issue_valid && !bus_io.issue_stall;

    set_mask = '0;
    clr_mask = '0;
    if (accept && bus_io.issue_long && (bus_io.issue_rd != '0)) begin
      set_mask[bus_io.issue_rd] = 1'b1;
    end
    if (b_ready) begin
      clr_mask[bus_io.b_rd] = 1'b1;
    end
    // Set applied after clear so a forced same-register collision leaves it busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    if (a_ready && (bus_io.a_rd != '0)) begin
      wr_d = '{en: 1'b1, addr: bus_io.a_rd, data: bus_io.a_data};
    end else if (b_ready && (bus_io.b_rd != '0)) begin
      wr_d = '{en: 1'b1, addr: bus_io.b_rd, data: bus_io.b_data};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      wr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
    end
  end

  assign bus_io.a_ready = a_ready;
  assign bus_io.b_ready = b_ready;
  assign bus_io.reg_wr  = wr_q.en;
  assign bus_io.rd_addr = wr_q.addr;
  assign bus_io.rd_data = wr_q.data;
  assign bus_io.busy    = busy_q;

  // A long-unit writeback must target a register it actually owes.
  b_owes_rd: assert property (@(posedge clk_i) disable iff (rst_i)
    bus_io.b_valid |-> busy_q[bus_io.b_rd]);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomised and directed bench for regfile_wb_ctrl against a behavioural scoreboard model.
module tb_regfile_wb_ctrl;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(
    .MaxWait (MAX_WAIT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit          m_busy [32];
  int          m_refused;
  bit          m_wr;
  int unsigned m_addr;
  int unsigned m_data;
  bit          obs_b_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_refused = 0;
    m_wr = 0;
    m_addr = 0;
    m_data = 0;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_long = 0;
    bus.issue_rd = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
  endtask

  // Long unit requests the lowest register it currently owes, if any.
  task automatic pick_b(input bit want);
    bus.b_valid = 0;
    bus.b_rd = 0;
    if (want) begin
      for (int i = 31; i >= 1; i--) begin
        if (m_busy[i]) begin
          bus.b_valid = 1;
          bus.b_rd = 5'(i);
        end
      end
    end
    bus.b_data = $urandom;
  endtask

  task automatic issue(input bit v, input bit lng, input int rd, input int rs1, input int rs2);
    bus.issue_valid = v; bus.issue_long = lng;
    bus.issue_rd = 5'(rd); bus.issue_rs1 = 5'(rs1); bus.issue_rs2 = 5'(rs2);
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit st, ar, br, prio;
    int wa;
    int unsigned wd;
    #1;
    st = bus.issue_valid && (m_busy[bus.issue_rd] || m_busy[bus.issue_rs1] ||
                             m_busy[bus.issue_rs2]);
    prio = bus.b_valid && (m_refused >= MAX_WAIT);
    ar = bus.a_valid && !prio;
    br = bus.b_valid && (!bus.a_valid || prio);
    check("issue_stall", bus.issue_stall, st);
    check("a_ready", bus.a_ready, ar);
    check("b_ready", bus.b_ready, br);
    obs_b_ready = bus.b_ready;
    @(posedge clk);
    if (br) m_busy[bus.b_rd] = 0;
    if (bus.issue_valid && !st && bus.issue_long && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
    if (bus.b_valid && !br) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
    else m_refused = 0;
    m_wr = 0;
    if (ar || br) begin
      wa = ar ? int'(bus.a_rd) : int'(bus.b_rd);
      wd = ar ? bus.a_data : bus.b_data;
      if (wa != 0) begin
        m_wr = 1; m_addr = wa; m_data = wd;
      end
    end
    #1;
    check("busy", bus.busy, busy_vec());
    check("reg_wr", bus.reg_wr, m_wr);
    check("rd_addr", bus.rd_addr, m_addr);
    check("rd_data", bus.rd_data, m_data);
  endtask

  initial begin
    int first_b, second_b, stall_cycles;
    logic [31:0] hold_addr, hold_data;

    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_busy", bus.busy, 32'h0);
    check("reset_reg_wr", bus.reg_wr, 1'b0);
    check("reset_rd_addr", bus.rd_addr, 5'd0);
    check("reset_rd_data", bus.rd_data, 32'h0);

    // RAW: long rd=5 then a consumer of x5 waits for B
    issue(1, 1, 5, 0, 0); cycle();
    issue(1, 0, 6, 5, 0);
    repeat (3) cycle();
    check("raw_stall_held", bus.issue_stall, 1'b1);
    bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 32'h1234;
    cycle();
    check("raw_commit_data", bus.rd_data, 32'h1234);
    pick_b(0);
    #1;
    check("raw_stall_drops", bus.issue_stall, 1'b0);
    cycle();

    // Contention: A always requesting, B owes x9 then x10
    issue(1, 1, 9, 0, 0); cycle();
    issue(1, 1, 10, 0, 0); cycle();
    issue(0, 0, 0, 0, 0);
    first_b = 0; second_b = 0;
    for (int c = 1; c <= 12; c++) begin
      bus.a_valid = 1; bus.a_rd = 3; bus.a_data = $urandom;
      pick_b(1);
      cycle();
      if (obs_b_ready) begin
        if (first_b == 0) first_b = c;
        else if (second_b == 0) second_b = c;
      end
    end
    check("contention_first_b", first_b, 5);
    check("contention_second_b", second_b, 10);
    idle_inputs();

    // x0: long issue to x0 stays clear; A write to x0 handshakes without writing
    issue(1, 1, 0, 0, 0); cycle();
    check("x0_not_busy", bus.busy, 32'h0);
    issue(0, 0, 0, 0, 0);
    bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'hFFFF_FFFF;
    cycle();
    check("x0_no_write", bus.reg_wr, 1'b0);
    bus.a_valid = 0;

    // WAW on x7
    issue(1, 1, 7, 0, 0); cycle();
    issue(1, 0, 7, 1, 2);
    stall_cycles = 0;
    for (int c = 0; c < 20 && bus.issue_stall !== 1'b0; c++) begin
      pick_b(c >= 2);
      cycle();
      if (bus.issue_stall) stall_cycles++;
    end
    check("waw_released", bus.issue_stall, 1'b0);
    check("waw_stalled_first", stall_cycles > 0, 1'b1);
    idle_inputs();
    cycle();

    // Idle
    hold_addr = bus.rd_addr; hold_data = bus.rd_data;
    repeat (10) cycle();
    check("idle_addr_hold", bus.rd_addr, hold_addr);
    check("idle_data_hold", bus.rd_data, hold_data);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      issue($urandom % 2, ($urandom % 3) == 0, $urandom % 8, $urandom % 8, $urandom % 8);
      bus.a_valid = $urandom % 2; bus.a_rd = 5'($urandom); bus.a_data = $urandom;
      pick_b($urandom % 2);
      cycle();
    end

    // Reset mid-operation with x4 owed
    idle_inputs();
    issue(1, 1, 4, 0, 0);
    bus.a_valid = 1; bus.a_rd = 8; bus.a_data = 32'hCAFE;
    cycle();
    idle_inputs();
    #3 rst = 1;
    #1;
    check("async_busy", bus.busy, 32'h0);
    check("async_reg_wr", bus.reg_wr, 1'b0);
    check("async_rd_addr", bus.rd_addr, 5'd0);
    check("async_rd_data", bus.rd_data, 32'h0);
    #1 rst = 0;
    model_reset();
    @(posedge clk);
    #1;
    bus.a_valid = 1; bus.a_rd = 12; bus.a_data = 32'h5555_AAAA;
    cycle();
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the single register-file write port and arbitrates it between two writers:
  - pipeline writeback (requester A, single-cycle ops and loads);
  - long-latency unit writeback (requester B, mul/div).
- Keeps a 32-entry busy scoreboard of registers owed by B, and stalls issue on RAW/WAW hazards against them.
- Sits between the ID/WB stages and the register file. It drives regWr/rd_addr/rd_data through registered outputs.

Parameters:
- MAX_WAIT, 4, consecutive cycles B may be refused before B gets priority (1..15).
- XLEN, 32, data width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction in ID wants to issue
- issue_long  in  1  issuing instruction completes via long unit (B)
- issue_rd  in  5  destination register of issuing instruction
- issue_rs1  in  5  source 1 (0 = unused)
- issue_rs2  in  5  source 2 (0 = unused)
- issue_stall  out  1  hazard; ID must hold instruction
- a_valid  in  1  pipeline writeback request
- a_rd  in  5  pipeline writeback address
- a_data  in  XLEN  pipeline writeback data
- a_ready  out  1  A granted this cycle
- b_valid  in  1  long-unit writeback request
- b_rd  in  5  long-unit writeback address
- b_data  in  XLEN  long-unit writeback data
- b_ready  out  1  B granted this cycle
- regWr  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- rd_data  out  XLEN  register-file write data (registered)
- busy  out  32  scoreboard vector (bit 0 always 0)

Behaviour:
- Reset (async, active-high, any cycle):
  - busy=0, wait_cnt=0, regWr=0, rd_addr=0, rd_data=0.
  - An in-flight grant is dropped. B must re-request after reset.
- Stall (combinational):
  - issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]).
  - Index 0 never busy.
- Issue accept: issue_valid & !issue_stall. If also issue_long & issue_rd!=0, set busy[issue_rd] at the next edge.
- Arbitration (combinational, one grant per cycle):
  - Default priority is A: a_ready = a_valid & !b_prio; b_ready = b_valid & (!a_valid | b_prio).
  - b_prio = (wait_cnt == MAX_WAIT) & b_valid.
- Wait counter:
  - Increments when b_valid & !b_ready.
  - Clears on a B grant or when !b_valid.
  - Saturates at MAX_WAIT.
- Commit (registered, latency 1): on the edge after a grant:
  - regWr=1, rd_addr/rd_data = granted requester's fields.
  - No grant → regWr=0, addr/data hold last value.
  - Granted rd=0 → handshake completes, regWr=0 (x0 never written).
- Scoreboard clear: B grant clears busy[b_rd] on the same edge the write is registered. The register file captures on the following negedge, so an issue in the next cycle reads the correct value.
- Simultaneous set and clear on the same rd cannot occur, because WAW stalls issue. If it is forced anyway, set wins.
- b_valid with busy[b_rd]==0 is a protocol error. It is still written; a simulation-only assertion flags it.
- A back-to-back: A granted every cycle while B absent, one write per cycle.

Decomposition:
- Shared package holds XLEN, REG_CNT=32, REG_AW=5, and the write-port struct (en, addr, data).
- One natural sub-module: wb_arbiter (priority select plus wait counter). The scoreboard and commit register stay in the top.

Test Plan:
- Reset mid-operation: busy=0x0000_0010, reset pulsed between edges → busy, regWr, rd_addr, rd_data all 0 immediately (async).
- Long issue rd=5, then issue with rs1=5 → issue_stall=1 until B writes rd=5, data=0x1234. Then regWr=1, rd_addr=5, rd_data=0x1234 one cycle later, busy[5]=0, stall drops the same cycle.
- Contention: a_valid and b_valid held high every cycle:
  - A wins 4 cycles (MAX_WAIT=4);
  - cycle 5 b_ready=1 and a_ready=0;
  - wait_cnt returns to 0, then A wins again.
- x0 handling: long issue rd=0 → busy stays 0. A write a_rd=0, data=0xFFFF_FFFF → a_ready=1, regWr=0.
- WAW: long issue rd=7 outstanding, non-long issue rd=7 → issue_stall=1. After B completes rd=7 → issue accepted.
- Idle: no requests for 10 cycles → regWr=0 throughout, rd_addr/rd_data unchanged.
